// File: rtl/reset_seq_pkg.sv
// ---------------------------------------------------------------------------
// reset_seq_pkg
// Shared definitions for the reset sequencer: the sequencing FSM state type,
// the legal parameter ranges and a helper that sizes the cycle counters.
// ---------------------------------------------------------------------------
package reset_seq_pkg;

    // Sequencing FSM states.
    typedef enum logic [1:0] {
        ASSERT  = 2'd0,  // request active, every stage held in reset
        HOLD    = 2'd1,  // request gone, waiting out the common hold time
        RELEASE = 2'd2,  // releasing stages one gap apart
        DONE    = 2'd3   // every stage released
    } seq_state_e;

    // Parameter legality limits.
    localparam int MIN_STAGES      = 1;
    localparam int MAX_STAGES      = 8;
    localparam int MIN_HOLD_CYCLES = 1;
    localparam int MIN_STAGE_GAP   = 1;
    localparam int MIN_SYNC_STAGES = 2;

    // Width of the completed-sequence counter.
    localparam int SEQ_COUNT_W = 8;

    // Counter width large enough to hold max(hold_cycles, stage_gap).
    function automatic int cnt_width(input int hold_cycles, input int stage_gap);
        int longest;
        longest = (hold_cycles > stage_gap) ? hold_cycles : stage_gap;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/reset_sequencer_sync.sv
// ---------------------------------------------------------------------------
// reset_sequencer_sync
// Multi-flop synchronizer that brings the asynchronous reset request into
// the clk domain.
//   clk    : sampling clock
//   rst_n  : synchronous active-low reset, clears the whole chain
//   d      : asynchronous input
//   q      : synchronized output, STAGES clk edges behind d
// ---------------------------------------------------------------------------
module reset_sequencer_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    // NOTE: sequential state is only ever assigned with <= so every flop
    // samples the pre-edge value of its neighbours; with = the chain would
    // collapse into a single flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// ---------------------------------------------------------------------------
// reset_sequencer
// Turns an asynchronous reset request into NUM_STAGES staged, synchronous
// reset outputs. All stages assert together; once the request has gone they
// stay asserted HOLD_CYCLES cycles, then release from bit 0 upward one every
// STAGE_GAP cycles.
//   clk       : sole clock, rising edge
//   rst_n     : synchronous active-low reset; restarts the power-on sequence
//   rst_req   : asynchronous active-high reset request
//   stage_rst : active-high staged resets, bit 0 released first
//   busy      : high while the sequence is incomplete (always ~done)
//   done      : high while every stage is released
//   seq_count : number of completed sequences, wraps 255 -> 0
// ---------------------------------------------------------------------------
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_STAGES  = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rst_req,
    output logic [NUM_STAGES-1:0]  stage_rst,
    output logic                   busy,
    output logic                   done,
    output logic [SEQ_COUNT_W-1:0] seq_count
);

    // ------------------------------------------------------------------
    // Parameter legality
    // ------------------------------------------------------------------
    if (NUM_STAGES < MIN_STAGES || NUM_STAGES > MAX_STAGES) begin : g_bad_num_stages
        $error("reset_sequencer: NUM_STAGES=%0d outside %0d..%0d",
               NUM_STAGES, MIN_STAGES, MAX_STAGES);
    end
    if (HOLD_CYCLES < MIN_HOLD_CYCLES) begin : g_bad_hold_cycles
        $error("reset_sequencer: HOLD_CYCLES=%0d below %0d", HOLD_CYCLES, MIN_HOLD_CYCLES);
    end
    if (STAGE_GAP < MIN_STAGE_GAP) begin : g_bad_stage_gap
        $error("reset_sequencer: STAGE_GAP=%0d below %0d", STAGE_GAP, MIN_STAGE_GAP);
    end
    if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync_stages
        $error("reset_sequencer: SYNC_STAGES=%0d below %0d", SYNC_STAGES, MIN_SYNC_STAGES);
    end

    localparam int                CNT_W     = cnt_width(HOLD_CYCLES, STAGE_GAP);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);

    // ------------------------------------------------------------------
    // Request synchronizer
    // ------------------------------------------------------------------
    logic req_s;

    reset_sequencer_sync #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rst_req),
        .q     (req_s)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    seq_state_e             state_q,     state_d;
    logic [CNT_W-1:0]       hold_cnt_q,  hold_cnt_d;
    logic [CNT_W-1:0]       gap_cnt_q,   gap_cnt_d;
    logic [NUM_STAGES-1:0]  stage_rst_q, stage_rst_d;
    logic                   done_q,      done_d;
    logic                   busy_q,      busy_d;
    logic [SEQ_COUNT_W-1:0] seq_count_q, seq_count_d;
    logic                   release_step;

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        stage_rst_d  = stage_rst_q;
        done_d       = done_q;
        seq_count_d  = seq_count_q;
        release_step = 1'b0;

        if (req_s) begin
            // A live request wins from any state and restarts everything.
            state_d     = ASSERT;
            stage_rst_d = '1;
            hold_cnt_d  = '0;
            gap_cnt_d   = '0;
            done_d      = 1'b0;
        end else begin
            case (state_q)
                ASSERT: begin
                    state_d    = HOLD;
                    hold_cnt_d = '0;
                end
                HOLD: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        release_step = 1'b1;
                    end else begin
                        hold_cnt_d = hold_cnt_q + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        release_step = 1'b1;
                    end else begin
                        gap_cnt_d = gap_cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = HOLD;
                end
            endcase
        end

        // Stages release lowest bit first, so a left shift clears exactly
        // the next still-asserted bit; once it empties, the sequence is done.
        if (release_step) begin
            stage_rst_d = stage_rst_q << 1;
            gap_cnt_d   = '0;
            if (stage_rst_d == '0) begin
                state_d     = DONE;
                done_d      = 1'b1;
                seq_count_d = seq_count_q + SEQ_COUNT_W'(1);
            end else begin
                state_d = RELEASE;
            end
        end

        busy_d = ~done_d;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: there is no storage array here, so every flop is reset; rst_n
    // restarts the power-on sequence from a fully known state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= HOLD;
            hold_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            stage_rst_q <= '1;
            done_q      <= 1'b0;
            busy_q      <= 1'b1;
            seq_count_q <= '0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            stage_rst_q <= stage_rst_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            seq_count_q <= seq_count_d;
        end
    end

    assign stage_rst = stage_rst_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign seq_count = seq_count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_reset_sequencer
// Directed bench for reset_sequencer: a default-parameter instance and a
// minimal one (1 stage, hold 1, gap 1) share clk, rst_n and rst_req.
// Release cycles are measured from a reference negedge and compared with
// hand-computed offsets.
// ---------------------------------------------------------------------------
module tb_reset_sequencer;

    localparam int NS = 4;
    localparam int HC = 16;
    localparam int SG = 8;
    localparam int SS = 2;

    // Default-parameter release offsets from the first HOLD cycle.
    localparam int REL_OFS [NS] = '{16, 24, 32, 40};

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rst_req;
    logic [NS-1:0] stage_rst;
    logic          busy;
    logic          done;
    logic [7:0]    seq_count;

    logic [0:0]    stage_rst_min;
    logic          busy_min;
    logic          done_min;
    logic [7:0]    seq_count_min;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    reset_sequencer #(
        .NUM_STAGES  (NS),
        .HOLD_CYCLES (HC),
        .STAGE_GAP   (SG),
        .SYNC_STAGES (SS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rst_req   (rst_req),
        .stage_rst (stage_rst),
        .busy      (busy),
        .done      (done),
        .seq_count (seq_count)
    );

    reset_sequencer #(
        .NUM_STAGES  (1),
        .HOLD_CYCLES (1),
        .STAGE_GAP   (1),
        .SYNC_STAGES (2)
    ) dut_min (
        .clk       (clk),
        .rst_n     (rst_n),
        .rst_req   (rst_req),
        .stage_rst (stage_rst_min),
        .busy      (busy_min),
        .done      (done_min),
        .seq_count (seq_count_min)
    );

    task automatic check(input string tag, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     tag, actual, actual, expected, expected);
        end
    endtask

    // Advance n rising edges, ending on the following negedge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic wait_for(input string tag, input logic [NS-1:0] value, input int budget);
        int n = 0;
        while (stage_rst !== value && n < budget) begin
            step(1);
            n++;
        end
        check(tag, 32'(stage_rst), 32'(value));
    endtask

    // Track each bit's last 1->0 edge over the whole schedule; the cycle
    // index counts rising edges after the reference negedge the call starts on.
    task automatic measure(input string tag, input int base);
        int            fall_at [NS];
        logic [NS-1:0] prev;
        int            bad_flags = 0;
        for (int k = 0; k < NS; k++) fall_at[k] = -1;
        prev = stage_rst;
        for (int n = 1; n <= base + REL_OFS[NS-1] + 4; n++) begin
            step(1);
            for (int k = 0; k < NS; k++) begin
                if (prev[k] && !stage_rst[k]) fall_at[k] = n;
            end
            if (done !== (stage_rst == '0) || busy !== ~done) bad_flags++;
            prev = stage_rst;
        end
        for (int k = 0; k < NS; k++) begin
            check($sformatf("%s_release_bit%0d", tag, k), 32'(fall_at[k]), 32'(base + REL_OFS[k]));
        end
        check({tag, "_done_busy_track"}, 32'(bad_flags), 32'd0);
        check({tag, "_done_end"}, 32'(done), 32'd1);
    endtask

    initial begin
        int bad_hold;
        rst_n   = 1'b0;
        rst_req = 1'b0;
        @(negedge clk);

        // Reset state after one reset edge.
        step(1);
        check("rst_stage_rst", 32'(stage_rst), 32'hF);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_seq_count", 32'(seq_count), 32'd0);
        check("rst_min_stage_rst", 32'(stage_rst_min), 32'd1);
        check("rst_min_done", 32'(done_min), 32'd0);

        // Power-on: four reset cycles, then release rst_n.
        step(3);
        rst_n = 1'b1;
        fork
            begin
                step(1);
                check("min_stage_rst", 32'(stage_rst_min), 32'd0);
                check("min_done", 32'(done_min), 32'd1);
                check("min_busy", 32'(busy_min), 32'd0);
                check("min_seq_count", 32'(seq_count_min), 32'd1);
            end
        join_none
        measure("por", 0);
        check("por_seq_count", 32'(seq_count), 32'd1);

        // Request held 5 cycles after done.
        rst_req = 1'b1;
        step(2);
        check("req_sync_delay", 32'(stage_rst), 32'h0);
        step(1);
        check("req_stage_rst", 32'(stage_rst), 32'hF);
        check("req_done", 32'(done), 32'd0);
        check("req_busy", 32'(busy), 32'd1);
        check("req_seq_count", 32'(seq_count), 32'd1);
        step(2);
        rst_req = 1'b0;
        measure("req", 3);
        check("req_seq_count_end", 32'(seq_count), 32'd2);

        // One-period pulse, then a second pulse after stage 1 has released.
        rst_req = 1'b1;
        step(1);
        rst_req = 1'b0;
        wait_for("abort_reach_1100", 4'b1100, 60);
        rst_req = 1'b1;
        step(1);
        rst_req = 1'b0;
        step(2);
        check("abort_stage_rst", 32'(stage_rst), 32'hF);
        check("abort_done", 32'(done), 32'd0);
        check("abort_seq_count", 32'(seq_count), 32'd2);
        measure("abort", 1);
        check("abort_seq_count_end", 32'(seq_count), 32'd3);

        // rst_n pulse during RELEASE.
        rst_req = 1'b1;
        step(1);
        rst_req = 1'b0;
        wait_for("rstn_reach_1110", 4'b1110, 60);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        check("rstn_stage_rst", 32'(stage_rst), 32'hF);
        check("rstn_done", 32'(done), 32'd0);
        check("rstn_busy", 32'(busy), 32'd1);
        check("rstn_seq_count", 32'(seq_count), 32'd0);
        measure("rstn", 0);
        check("rstn_seq_count_end", 32'(seq_count), 32'd1);

        // Request held for 100 cycles: nothing may release meanwhile.
        rst_req  = 1'b1;
        bad_hold = 0;
        step(3);
        for (int i = 3; i < 100; i++) begin
            if (stage_rst !== 4'hF || busy !== 1'b1 || done !== 1'b0) bad_hold++;
            step(1);
        end
        check("long_req_bad_cycles", 32'(bad_hold), 32'd0);
        rst_req = 1'b0;
        measure("long", 3);
        check("long_seq_count_end", 32'(seq_count), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
